// File: rtl/sseg_scheduler_if.sv
// ---------------------------------------------------------------------------
// sseg_scheduler_if
//   Bundles the request side and the display side of the seven-segment
//   scheduler.
//   master : drives enable, lz_blank, req_valid, req_num0..2, req_dp0..2 and
//            req_blink. Observes num, dig_en, dp_en, src and src_valid.
//   slave  : the scheduler. Observes the requests and drives the display
//            outputs.
// ---------------------------------------------------------------------------
interface sseg_scheduler_if;
    logic        enable;
    logic        lz_blank;
    logic [2:0]  req_valid;
    logic [13:0] req_num0;
    logic [13:0] req_num1;
    logic [13:0] req_num2;
    logic [3:0]  req_dp0;
    logic [3:0]  req_dp1;
    logic [3:0]  req_dp2;
    logic [2:0]  req_blink;
    logic [13:0] num;
    logic [3:0]  dig_en;
    logic [3:0]  dp_en;
    logic [1:0]  src;
    logic        src_valid;

    modport master (
        output enable, lz_blank, req_valid, req_num0, req_num1, req_num2,
               req_dp0, req_dp1, req_dp2, req_blink,
        input  num, dig_en, dp_en, src, src_valid
    );

    modport slave (
        input  enable, lz_blank, req_valid, req_num0, req_num1, req_num2,
               req_dp0, req_dp1, req_dp2, req_blink,
        output num, dig_en, dp_en, src, src_valid
    );
endinterface

// File: rtl/sseg_scheduler.sv
// ---------------------------------------------------------------------------
// sseg_scheduler
//   Chooses which of three sources drives a 4-digit seven-segment display.
//   Source 0 preempts. Sources 1 and 2 share the display round-robin, and
//   each one is shown for DWELL cycles. The value is saturated to 9999. The
//   block also applies optional leading-zero blanking and per-source
//   blinking. All outputs are registered, so they follow the inputs with one
//   cycle of latency.
//   Ports: clk            - clock, rising edge
//          rst            - asynchronous reset, active low
//          bus (slave)    - request inputs and display outputs
// ---------------------------------------------------------------------------
module sseg_scheduler #(
    parameter int DWELL      = 8,
    parameter int BLINK_HALF = 4
) (
    input  logic            clk,
    input  logic            rst,
    sseg_scheduler_if.slave bus
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHOW_PRI = 2'd1,
        ST_SHOW_RR  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    cur_s, oth_s;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;
    logic [13:0]   num_q, num_d, sel_num_s;
    logic [3:0]    dig_en_q, dig_en_d, dp_en_q, dp_en_d, sel_dp_s;
    logic          src_valid_q, src_valid_d, sel_blink_s;

    function automatic logic [13:0] sat_num(input logic [13:0] v);
        sat_num = (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    function automatic logic [3:0] lz_mask(input logic [13:0] v);
        lz_mask = {(v >= 14'd1000), (v >= 14'd100), (v >= 14'd10), 1'b1};
    endfunction

    // Round-robin source that is current: after a preemption it is the source that was interrupted
    assign cur_s = (state_q == ST_SHOW_PRI) ? rr_ptr_q : src_q;
    assign oth_s = (cur_s == 2'd1) ? 2'd2 : 2'd1;

    // Next state, displayed source, dwell counter and resume pointer
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dwell_d  = dwell_q;
        rr_ptr_d = rr_ptr_q;
        if (!bus.enable) begin
            state_d = state_q;
        end else if (bus.req_valid[0]) begin
            state_d = ST_SHOW_PRI;
            src_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dwell_d = {DW{1'b0}};
                    if (bus.req_valid[1]) begin
                        state_d = ST_SHOW_RR;
                        src_d   = 2'd1;
                    end else if (bus.req_valid[2]) begin
                        state_d = ST_SHOW_RR;
                        src_d   = 2'd2;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHOW_PRI, ST_SHOW_RR: begin
                    if (!bus.req_valid[cur_s]) begin
                        // Current round-robin source is gone, so hand over or fall idle
                        dwell_d = {DW{1'b0}};
                        if (bus.req_valid[oth_s]) begin
                            state_d = ST_SHOW_RR;
                            src_d   = oth_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (state_q == ST_SHOW_PRI) begin
                        // Resume the interrupted source with a fresh dwell
                        state_d = ST_SHOW_RR;
                        src_d   = cur_s;
                        dwell_d = {DW{1'b0}};
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = {DW{1'b0}};
                        if (bus.req_valid[oth_s]) begin
                            src_d = oth_s;
                        end else begin
                            src_d = src_q;
                        end
                    end else begin
                        dwell_d = dwell_q + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dwell_d = {DW{1'b0}};
                end
            endcase
        end
        if (state_d == ST_SHOW_RR) begin
            rr_ptr_d = src_d;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Select the value, decimal points and blink request of the next source
    always_comb begin
        case (src_d)
            2'd0: begin
                sel_num_s   = bus.req_num0;
                sel_dp_s    = bus.req_dp0;
                sel_blink_s = bus.req_blink[0];
            end
            2'd1: begin
                sel_num_s   = bus.req_num1;
                sel_dp_s    = bus.req_dp1;
                sel_blink_s = bus.req_blink[1];
            end
            2'd2: begin
                sel_num_s   = bus.req_num2;
                sel_dp_s    = bus.req_dp2;
                sel_blink_s = bus.req_blink[2];
            end
            default: begin
                sel_num_s   = 14'd0;
                sel_dp_s    = 4'd0;
                sel_blink_s = 1'b0;
            end
        endcase
    end

    // Blink phase tracking and next values of the display outputs
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        num_d       = 14'd0;
        dig_en_d    = 4'd0;
        dp_en_d     = 4'd0;
        src_valid_d = 1'b0;
        if (!bus.enable) begin
            blink_cnt_d = blink_cnt_q;
        end else if (state_d == ST_IDLE) begin
            blink_cnt_d = {BW{1'b0}};
            blink_off_d = 1'b0;
        end else begin
            // A newly shown source always starts in the on phase
            if ((state_q == ST_IDLE) || (src_d != src_q)) begin
                blink_cnt_d = {BW{1'b0}};
                blink_off_d = 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = {BW{1'b0}};
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            end
            num_d       = sat_num(sel_num_s);
            src_valid_d = 1'b1;
            if (sel_blink_s && blink_off_d) begin
                dig_en_d = 4'd0;
                dp_en_d  = 4'd0;
            end else begin
                dig_en_d = bus.lz_blank ? lz_mask(num_d) : 4'b1111;
                dp_en_d  = sel_dp_s;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            src_q       <= 2'd1;
            rr_ptr_q    <= 2'd1;
            dwell_q     <= {DW{1'b0}};
            blink_cnt_q <= {BW{1'b0}};
            blink_off_q <= 1'b0;
            num_q       <= 14'd0;
            dig_en_q    <= 4'd0;
            dp_en_q     <= 4'd0;
            src_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            rr_ptr_q    <= rr_ptr_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            num_q       <= num_d;
            dig_en_q    <= dig_en_d;
            dp_en_q     <= dp_en_d;
            src_valid_q <= src_valid_d;
        end
    end

    assign bus.num       = num_q;
    assign bus.dig_en    = dig_en_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.src       = src_q;
    assign bus.src_valid = src_valid_q;
endmodule

// File: doc/sseg_scheduler.md
SSEG_SCHEDULER -- requirements
Module: sseg_scheduler

Interface
REQ-001 SHALL have parameter DWELL, default 8, meaning the number of cycles a round-robin source is shown before rotating (legal range 2..2^26).
REQ-002 SHALL have parameter BLINK_HALF, default 4, meaning the number of cycles per blink half-period (legal range 1..2^26).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: when 0, the display is blanked and scheduling is frozen.
REQ-006 SHALL have port lz_blank, input, 1 bit: leading-zero blanking enable.
REQ-007 SHALL have port req_valid, input, 3 bits: per-source display request; source 0 is priority, sources 1 and 2 are round-robin.
REQ-008 SHALL have ports req_num0, req_num1 and req_num2, input, 14 bits each: the per-source value.
REQ-009 SHALL have ports req_dp0, req_dp1 and req_dp2, input, 4 bits each: the per-source decimal-point enables.
REQ-010 SHALL have port req_blink, input, 3 bits: per-source blink request.
REQ-011 SHALL have port num, output, 14 bits: the value to the display controller.
REQ-012 SHALL have port dig_en, output, 4 bits: digit enables; bit 0 is the least significant digit.
REQ-013 SHALL have port dp_en, output, 4 bits: decimal-point enables.
REQ-014 SHALL have port src, output, 2 bits: the currently displayed source index.
REQ-015 SHALL have port src_valid, output, 1 bit: high while any source is displayed.

Function
REQ-016 SHALL implement the states IDLE, SHOW_PRI and SHOW_RR, held in a registered state variable.
REQ-017 SHALL evaluate transitions with priority in this order: enable=0 (hold the state and all counters), req_valid[0]=1 (go to SHOW_PRI, src=0), then round-robin, then IDLE.
REQ-018 SHALL move from IDLE to SHOW_RR when a round-robin source is valid, taking source 1 if req_valid[1]=1 and otherwise source 2.
REQ-019 SHALL, in SHOW_RR, increment the dwell counter each enabled cycle; at count DWELL-1 it SHALL switch src to the other round-robin source if that source is valid, otherwise keep src, and in both cases clear the counter.
REQ-020 SHALL, in SHOW_RR, switch on the next cycle to the other round-robin source (counter cleared) when the current source deasserts valid and the other source is valid; if neither is valid it SHALL go to IDLE.
REQ-021 SHALL, on leaving SHOW_PRI, resume at the round-robin source shown before the preemption with its dwell counter cleared; if that source is no longer valid, REQ-020 applies.
REQ-022 SHALL register all outputs, with one cycle of latency from the inputs; num and dp_en SHALL track the selected source live every cycle.
REQ-023 SHALL saturate num to 9999 when the selected request value is greater than 9999.
REQ-024 SHALL, with lz_blank=1, drive dig_en from the output value: bit3 = (num>=1000), bit2 = (num>=100), bit1 = (num>=10), bit0 = 1.
REQ-025 SHALL, with lz_blank=0, drive dig_en=4'b1111 while a source is displayed.
REQ-026 SHALL, with the displayed source's req_blink=1, blank dig_en and dp_en during each off half-period; the blink phase SHALL toggle every BLINK_HALF cycles, start in the on phase, and restart in the on phase on every src change.
REQ-027 SHALL, in IDLE or when enable=0, drive dig_en=0, dp_en=0, src_valid=0 and num=0, with src holding its last value.
REQ-028 SHALL, when every source except the current one deasserts in the same cycle that dwell expires, keep the current source; a source-0 assertion SHALL win over a simultaneous dwell expiry.

Reset
REQ-029 SHALL, while rst=0, immediately drive state=IDLE, src=1, src_valid=0, num=0, dig_en=0 and dp_en=0, clear the dwell and blink counters, and set the resume pointer to source 1.
REQ-030 SHALL, when rst is asserted mid-dwell or mid-preemption, discard the pending rotation, and after reset release SHALL re-enter scheduling per REQ-018.

Verification
REQ-031 The bench SHALL cover: req_valid=3'b110, num1=42, num2=1234, DWELL=8, lz_blank=1 -> outputs alternate every 8 cycles between num=42 with dig_en=0011 and num=1234 with dig_en=1111.
REQ-032 The bench SHALL cover: req_valid[0] raised mid-dwell of source 2, with num0=7 -> next cycle src=0, num=7, dig_en=0001; on release, source 2 is shown for a full 8 cycles.
REQ-033 The bench SHALL cover: req_num1=16383 with req_dp1=4'b0100 -> num=9999, dp_en=0100.
REQ-034 The bench SHALL cover: req_blink[1]=1 with BLINK_HALF=4 -> dig_en is on for 4 cycles and off for 4 cycles, with the phase restarting at each src change.
REQ-035 The bench SHALL cover: all req_valid deasserted -> one cycle later src_valid=0 and dig_en=0; then rst pulsed low asynchronously between clock edges -> outputs are cleared before the next edge.
REQ-036 The bench SHALL cover: enable=0 for 20 cycles in SHOW_RR -> display blank and dwell count frozen, with rotation resuming at the preserved count after enable returns to 1.
